lc3_mem_responder: RTL and testbench

//  Memory-side responder for the LC3 pipeline's memory interface: one fetch read port, two data read

---
 rtl/lc3_mem_pkg.sv | 10 +
 rtl/lc3_mem_array.sv | 27 ++
 rtl/lc3_mem_responder.sv | 80 ++++++++
 tb/tb_lc3_mem_responder.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/lc3_mem_pkg.sv
// lc3_mem_pkg: shared types, default widths and index helper for the LC3 memory responder.
package lc3_mem_pkg;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DEPTH = 1024;
  typedef enum logic [1:0] {CLEAR, LOAD, RUN} memState_t;
  function automatic int idxBits(input int depth);
    return $clog2(depth);
  endfunction
endpackage

// File: rtl/lc3_mem_array.sv
// lc3_mem_array: word storage with one write port and three registered, write-first read ports.
module lc3_mem_array import lc3_mem_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH = DEF_DEPTH,
  localparam int IW = idxBits(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   live,
  input  logic                   we,
  input  logic [IW-1:0]          wIdx,
  input  logic [DATA_W-1:0]      wData,
  input  logic [2:0]             rdEn,
  input  logic [2:0][IW-1:0]     rdIdx,
  output logic [2:0][DATA_W-1:0] rdData
);
  logic [DATA_W-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[wIdx] <= wData;
  // Read registers hold when their port is idle; the CPU relies on that during stalls.
  always_ff @(posedge clk or posedge rst)
    if (rst) rdData <= '0;
    else
      for (int i = 0; i < 3; i++)
        if (!live) rdData[i] <= '0;
        else if (rdEn[i]) rdData[i] <= (we && wIdx == rdIdx[i]) ? wData : mem[rdIdx[i]];
endmodule

// File: rtl/lc3_mem_responder.sv
// lc3_mem_responder: clears storage, accepts a loader image, then serves the LC3 CPU ports.
module lc3_mem_responder import lc3_mem_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_en,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [DATA_W-1:0] fetch_data,
  input  logic              ld0_en,
  input  logic [ADDR_W-1:0] ld0_addr,
  output logic [DATA_W-1:0] ld0_data,
  input  logic              ld1_en,
  input  logic [ADDR_W-1:0] ld1_addr,
  output logic [DATA_W-1:0] ld1_data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              init_valid,
  output logic              init_ready,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic [DATA_W-1:0] init_data,
  input  logic              init_last,
  output logic              mem_ready
);
  localparam int IW = idxBits(DEPTH);
  localparam logic [IW:0] CLR_LAST = DEPTH[IW:0] - 1'b1;
  memState_t state;
  logic [IW:0] clrCnt;
  logic initFire, we;
  logic [IW-1:0] wIdx;
  logic [DATA_W-1:0] wData;
  logic [2:0][DATA_W-1:0] rdData;
  assign initFire = init_valid && init_ready;
  // One write port shared by the clear sweep, the loader and the CPU, selected by phase.
  always_comb begin
    we = state == CLEAR || initFire || (state == RUN && wr_en);
    wIdx = state == CLEAR ? clrCnt[IW-1:0] : state == LOAD ? init_addr[IW-1:0] : wr_addr[IW-1:0];
    wData = state == RUN ? wr_data : state == LOAD ? init_data : '0;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= CLEAR;
      clrCnt <= '0;
      init_ready <= 1'b0;
      mem_ready <= 1'b0;
    end else
      case (state)
        CLEAR: begin
          clrCnt <= clrCnt + 1'b1;
          if (clrCnt == CLR_LAST) begin
            state <= LOAD;
            init_ready <= 1'b1;
          end
        end
        LOAD:
          if (initFire && init_last) begin
            state <= RUN;
            init_ready <= 1'b0;
            mem_ready <= 1'b1;
          end
        default: ;
      endcase
  lc3_mem_array #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_array (
    .clk(clk),
    .rst(rst),
    .live(state == RUN),
    .we(we),
    .wIdx(wIdx),
    .wData(wData),
    .rdEn({ld1_en, ld0_en, fetch_en}),
    .rdIdx({ld1_addr[IW-1:0], ld0_addr[IW-1:0], fetch_addr[IW-1:0]}),
    .rdData(rdData)
  );
  assign fetch_data = rdData[0];
  assign ld0_data = rdData[1];
  assign ld1_data = rdData[2];
endmodule

// File: tb/tb_lc3_mem_responder.sv
// tb_lc3_mem_responder: random and directed checks against a word-array model of the responder.
module tb_lc3_mem_responder;
  logic clk = 1'b0, rst = 1'b1;
  logic fetch_en, ld0_en, ld1_en, wr_en, init_valid, init_last, init_ready, mem_ready;
  logic [15:0] fetch_addr, ld0_addr, ld1_addr, wr_addr, wr_data, init_addr, init_data;
  logic [15:0] fetch_data, ld0_data, ld1_data;
  int tests = 0, fails = 0;
  logic [15:0] model [1024];
  int phase, clrLeft, n;
  logic [15:0] expF, exp0, exp1, old;

  lc3_mem_responder dut (
    .clk(clk), .rst(rst),
    .fetch_en(fetch_en), .fetch_addr(fetch_addr), .fetch_data(fetch_data),
    .ld0_en(ld0_en), .ld0_addr(ld0_addr), .ld0_data(ld0_data),
    .ld1_en(ld1_en), .ld1_addr(ld1_addr), .ld1_data(ld1_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .init_valid(init_valid), .init_ready(init_ready), .init_addr(init_addr),
    .init_data(init_data), .init_last(init_last), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int ix(input logic [15:0] a);
    return int'(a) % 1024;
  endfunction

  function automatic logic [15:0] rAddr();
    return 16'(($urandom & 32'hFC00) | $urandom_range(0, 15));
  endfunction

  task automatic idle();
    {fetch_en, ld0_en, ld1_en, wr_en, init_valid, init_last} = '0;
    {fetch_addr, ld0_addr, ld1_addr, wr_addr, wr_data, init_addr, init_data} = '0;
  endtask

  task automatic randCpu();
    fetch_en = 1'($urandom); ld0_en = 1'($urandom); ld1_en = 1'($urandom); wr_en = 1'($urandom);
    fetch_addr = rAddr(); ld0_addr = rAddr(); ld1_addr = rAddr(); wr_addr = rAddr();
    wr_data = 16'($urandom);
    init_valid = 1'($urandom); init_last = 1'($urandom);
    init_addr = rAddr(); init_data = 16'($urandom);
  endtask

  // Model: three phases; a write lands before same-cycle reads, giving write-first behaviour.
  task automatic cycle();
    int nextPhase = phase;
    if (phase == 2 && wr_en) model[ix(wr_addr)] = wr_data;
    if (phase == 1 && init_valid) begin
      model[ix(init_addr)] = init_data;
      if (init_last) nextPhase = 2;
    end
    if (phase == 2) begin
      if (fetch_en) expF = model[ix(fetch_addr)];
      if (ld0_en) exp0 = model[ix(ld0_addr)];
      if (ld1_en) exp1 = model[ix(ld1_addr)];
    end else begin
      expF = 0; exp0 = 0; exp1 = 0;
    end
    @(posedge clk); #1;
    if (phase == 0) begin
      clrLeft--;
      if (clrLeft == 0) nextPhase = 1;
    end
    phase = nextPhase;
    check("fetch_data", fetch_data, expF);
    check("ld0_data", ld0_data, exp0);
    check("ld1_data", ld1_data, exp1);
    check("mem_ready", 16'(mem_ready), 16'(phase == 2));
    check("init_ready", 16'(init_ready), 16'(phase == 1));
  endtask

  task automatic doReset();
    idle();
    rst = 1'b1;
    #1;
    phase = 0; clrLeft = 1024; expF = 0; exp0 = 0; exp1 = 0;
    for (int i = 0; i < 1024; i++) model[i] = '0;
    check("rst_fetch", fetch_data, 16'h0);
    check("rst_ld0", ld0_data, 16'h0);
    check("rst_ld1", ld1_data, 16'h0);
    check("rst_init_ready", 16'(init_ready), 16'h0);
    check("rst_mem_ready", 16'(mem_ready), 16'h0);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic runClear();
    n = 0;
    do begin
      randCpu();
      cycle();
      n++;
    end while (!init_ready && n < 2000);
    check("clear_len", 16'(n), 16'd1024);
    idle();
  endtask

  initial begin
    idle();
    #2;
    doReset();
    runClear();
    for (int i = 0; i < 20; i++) begin
      randCpu();
      init_last = 1'b0;
      cycle();
    end
    idle();
    init_valid = 1'b1; init_addr = 16'h0000; init_data = 16'h1220;
    cycle();
    init_addr = 16'h0001; init_data = 16'hF025; init_last = 1'b1;
    cycle();
    check("load_mem_ready", 16'(mem_ready), 16'h1);
    idle();
    fetch_en = 1'b1; fetch_addr = 16'h0000;
    cycle();
    check("fetch0", fetch_data, 16'h1220);
    fetch_addr = 16'h0001;
    cycle();
    check("fetch1", fetch_data, 16'hF025);
    idle();
    wr_en = 1'b1; wr_addr = 16'h0040; wr_data = 16'hBEEF;
    fetch_en = 1'b1; ld0_en = 1'b1; ld1_en = 1'b1;
    fetch_addr = 16'h0040; ld0_addr = 16'h0040; ld1_addr = 16'h0040;
    cycle();
    check("rdw_fetch", fetch_data, 16'hBEEF);
    check("rdw_ld0", ld0_data, 16'hBEEF);
    check("rdw_ld1", ld1_data, 16'hBEEF);
    idle();
    wr_en = 1'b1; wr_addr = 16'h0405; wr_data = 16'h1234;
    cycle();
    idle();
    ld0_en = 1'b1; ld0_addr = 16'h0005;
    cycle();
    check("alias_ld0", ld0_data, 16'h1234);
    idle();
    old = model[3];
    ld1_en = 1'b1; ld1_addr = 16'h0003;
    cycle();
    idle();
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_addr = 16'h0003; wr_data = 16'($urandom) | 16'h8000;
      cycle();
      check("ld1_hold", ld1_data, old);
    end
    for (int i = 0; i < 400; i++) begin
      randCpu();
      cycle();
    end
    doReset();
    runClear();
    init_valid = 1'b1; init_addr = 16'h0007; init_data = 16'hA5A5;
    wr_en = 1'b1; wr_addr = 16'h0008; wr_data = 16'h5A5A;
    cycle();
    doReset();
    runClear();
    init_valid = 1'b1; init_addr = 16'h0009; init_data = 16'h0909; init_last = 1'b1;
    wr_en = 1'b1; wr_addr = 16'h0007; wr_data = 16'hFFFF;
    cycle();
    idle();
    ld0_en = 1'b1; ld0_addr = 16'h0007; ld1_en = 1'b1; ld1_addr = 16'h0008;
    fetch_en = 1'b1; fetch_addr = 16'h0409;
    cycle();
    check("discard_ld0", ld0_data, 16'h0);
    check("cpu_wr_ignored", ld1_data, 16'h0);
    check("reload_fetch", fetch_data, 16'h0909);
    idle();
    for (int i = 0; i < 50; i++) begin
      randCpu();
      wr_en = 1'b0;
      cycle();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
